led_fill_pattern: RTL and testbench
===================================

LED_FILL_PATTERN -- requirements
Module: led_fill_pattern

Interface
REQ-001 The block SHALL have parameter HALF, default 4, giving LEDs per half; WIDTH = 2*HALF; legal HALF is 2..16.
REQ-002 The block SHALL have parameter DIV, default 1, giving clocks per pattern step; legal DIV is 1..65535.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  enables the prescaler and pattern stepping; low SHALL freeze all state.
REQ-006 start  input  1  one-cycle request to begin a sequence; SHALL latch mode and loop.
REQ-007 mode  input  2  pattern select: 00 inside-out, 01 outside-in, 10 fill from MSB, 11 fill from LSB.
REQ-008 loop  input  1  1 = repeat the sequence forever; 0 = one-shot.
REQ-009 q  output  WIDTH  LED pattern, registered.
REQ-010 busy  output  1  high in RUN and FULL states.
REQ-011 done  output  1  one-clock pulse when a one-shot sequence completes.

Function
REQ-012 Prescaler: a counter SHALL advance only when en=1 and the FSM is not IDLE; step_tick SHALL assert when count==DIV-1, after which the count SHALL return to 0; DIV=1 SHALL tick every enabled cycle.
REQ-013 FSM states SHALL be IDLE, RUN, FULL and DONE.
- IDLE→RUN on start.
- RUN→FULL on the tick that makes q all ones.
- FULL→RUN (q cleared) on the next tick if the latched loop=1.
- FULL→DONE (q held all ones) on the next tick if the latched loop=0.
- DONE→RUN on start.
REQ-014 On start, q SHALL clear to 0 and the prescaler SHALL clear; the first LED SHALL light on the first tick after start.
REQ-015 start asserted in RUN or FULL SHALL restart the sequence with the newly latched mode and loop, and SHALL NOT pulse done.
REQ-016 mode and loop changes outside a start cycle SHALL be ignored.
REQ-017 Mode 00, per tick:
- Lower half SHALL shift right with 1 inserted at bit HALF-1.
- Upper half SHALL shift left with 1 inserted at bit HALF.
- The pattern fills from the centre outward in HALF ticks.
REQ-018 Mode 01, per tick:
- Lower half SHALL shift left with 1 inserted at bit 0.
- Upper half SHALL shift right with 1 inserted at bit WIDTH-1.
- The pattern fills from the outside inward in HALF ticks.
REQ-019 Mode 10: per tick, q SHALL shift right with 1 inserted at bit WIDTH-1; the pattern fills in WIDTH ticks.
REQ-020 Mode 11: per tick, q SHALL shift left with 1 inserted at bit 0; the pattern fills in WIDTH ticks.
REQ-021 Each step SHALL fill exactly one LED per active half (modes 00/01) or one LED in total (modes 10/11), with no wrap into the other half.
REQ-022 In FULL and DONE, q SHALL be all ones; in IDLE, q SHALL be 0.
REQ-023 done SHALL pulse high for exactly one clock on the FULL→DONE transition and SHALL be 0 otherwise.
REQ-024 en=0 SHALL hold q, the state and the prescaler count; start SHALL still be accepted while en=0.
REQ-025 start and a step tick in the same cycle: start SHALL win.

Reset
REQ-026 On reset the block SHALL enter IDLE with q=0, busy=0, done=0, prescaler=0, latched mode=00 and latched loop=0, immediately and regardless of clk.
REQ-027 Reset asserted mid-sequence SHALL abort the sequence; no done pulse SHALL be produced.

Verification
REQ-028 HALF=4, DIV=1, mode=00, loop=1, en=1, start: q SHALL read 0x18, 0x3C, 0x7E, 0xFF, 0x00, 0x18, ... on successive clocks.
REQ-029 mode=01, loop=0: q SHALL read 0x81, 0xC3, 0xE7, 0xFF, then hold 0xFF; done SHALL pulse once one tick after FULL; busy SHALL fall at the same time.
REQ-030 mode=10 and mode=11: q SHALL read 0x80, 0xC0, ..., 0xFF and 0x01, 0x03, ..., 0xFF respectively, each in 8 ticks.
REQ-031 DIV=3, mode=00: q SHALL change only every 3rd enabled clock; dropping en for 5 clocks SHALL extend the sequence by exactly 5 clocks.
REQ-032 Async reset during q=0x3C, between clock edges: q SHALL read 0x00 and busy 0 before the next edge; start mid-run with mode changed to 11 SHALL give q=0x00, then 0x01.

Source files
------------

// File: rtl/led_fill_pattern.sv
// LED fill-pattern sequencer: four fill modes, one-shot or looping, one LED step per prescaler tick.
// q/busy/done are registered and update one clock after the tick or start that causes them; en=0 freezes everything except start.
module led_fill_pattern #(
    parameter int HALF = 4,
    parameter int DIV  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic                loop,
    output logic [2*HALF-1:0]   q,
    output logic                busy,
    output logic                done
);

    localparam int WIDTH = 2 * HALF;
    localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, FULL, DONE} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         mode_q;
    logic               loop_q;
    logic [WIDTH-1:0]   q_q, step_d;
    logic               busy_q, done_q;
    logic               active, tick;
    logic [HALF-1:0]    lo, hi;

    assign lo = q_q[HALF-1:0];
    assign hi = q_q[WIDTH-1:HALF];

    always_comb begin
        active = en && (state_q != IDLE);
        tick   = active && (cnt_q == DIV_M1);
        cnt_d  = tick ? '0 : cnt_q + 1'b1;
        step_d = q_q;
        // Halves are shifted independently so a fill never spills across the centre.
        case (mode_q)
            2'b00:   step_d = {hi[HALF-2:0], 1'b1, 1'b1, lo[HALF-1:1]};
            2'b01:   step_d = {1'b1, hi[HALF-1:1], lo[HALF-2:0], 1'b1};
            2'b10:   step_d = {1'b1, q_q[WIDTH-1:1]};
            default: step_d = {q_q[WIDTH-2:0], 1'b1};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            loop_q  <= 1'b0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                // Start overrides any tick in the same cycle and is honoured even with en low.
                state_q <= RUN;
                cnt_q   <= '0;
                mode_q  <= mode;
                loop_q  <= loop;
                q_q     <= '0;
                busy_q  <= 1'b1;
            end else if (active) begin
                cnt_q <= cnt_d;
                if (tick) begin
                    case (state_q)
                        RUN: begin
                            q_q <= step_d;
                            if (&step_d) state_q <= FULL;
                        end
                        FULL: begin
                            if (loop_q) begin
                                q_q     <= '0;
                                state_q <= RUN;
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign q    = q_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_fill_pattern.sv
// Directed bench: HALF=4 instances with DIV=1 and DIV=3, expected patterns hand-computed.
module tb_led_fill_pattern;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en1 = 1'b1, start1 = 1'b0, loop1 = 1'b0;
    logic [1:0] mode1 = 2'b00;
    logic [7:0] q1;
    logic       busy1, done1;
    logic       en3 = 1'b1, start3 = 1'b0, loop3 = 1'b0;
    logic [1:0] mode3 = 2'b00;
    logic [7:0] q3;
    logic       busy3, done3;

    int errors = 0;
    int checks = 0;

    logic [7:0] e00[6] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h00, 8'h18};
    logic [7:0] e01[4] = '{8'h81, 8'hC3, 8'hE7, 8'hFF};
    logic [7:0] e10[8] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    logic [7:0] e11[8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [7:0] e3[5]  = '{8'h00, 8'h18, 8'h3C, 8'h7E, 8'hFF};

    led_fill_pattern #(.HALF(4), .DIV(1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en1), .start(start1), .mode(mode1),
        .loop(loop1), .q(q1), .busy(busy1), .done(done1));

    led_fill_pattern #(.HALF(4), .DIV(3)) u_dut3 (
        .clk(clk), .reset(reset), .en(en3), .start(start3), .mode(mode3),
        .loop(loop3), .q(q3), .busy(busy3), .done(done3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one clock, then scramble mode/loop so any late latching shows up.
    task automatic start_dut1(input logic [1:0] m, input logic l);
        start1 = 1'b1;
        mode1  = m;
        loop1  = l;
        clk1();
        start1 = 1'b0;
        mode1  = ~m;
        loop1  = ~l;
        chk("start_q", q1, 8'h00);
        chk("start_busy", busy1, 1'b1);
        chk("start_done", done1, 1'b0);
    endtask

    initial begin
        int n;
        #1;
        chk("rst_q1", q1, 8'h00);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_done1", done1, 1'b0);
        chk("rst_q3", q3, 8'h00);
        #12 reset = 1'b0;

        // inside-out, looping
        start_dut1(2'b00, 1'b1);
        for (int i = 0; i < 6; i++) begin
            clk1();
            chk($sformatf("m00_q%0d", i), q1, e00[i]);
            chk($sformatf("m00_busy%0d", i), busy1, 1'b1);
            chk($sformatf("m00_done%0d", i), done1, 1'b0);
        end

        // restart mid-run with outside-in one-shot
        start_dut1(2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clk1();
            chk($sformatf("m01_q%0d", i), q1, e01[i]);
            chk($sformatf("m01_done%0d", i), done1, 1'b0);
        end
        clk1();
        chk("m01_done_pulse", done1, 1'b1);
        chk("m01_busy_fall", busy1, 1'b0);
        chk("m01_q_hold", q1, 8'hFF);
        clk1();
        chk("m01_done_end", done1, 1'b0);
        chk("m01_q_hold2", q1, 8'hFF);

        // fill from MSB, then from LSB, each started from DONE
        start_dut1(2'b10, 1'b0);
        for (int i = 0; i < 8; i++) begin
            clk1();
            chk($sformatf("m10_q%0d", i), q1, e10[i]);
        end
        clk1();
        chk("m10_done", done1, 1'b1);
        start_dut1(2'b11, 1'b0);
        for (int i = 0; i < 8; i++) begin
            clk1();
            chk($sformatf("m11_q%0d", i), q1, e11[i]);
        end
        clk1();
        chk("m11_done", done1, 1'b1);

        // en=0 freezes q; start still accepted while en=0
        start_dut1(2'b11, 1'b1);
        clk1();
        chk("en_pre", q1, 8'h01);
        en1 = 1'b0;
        clk1();
        clk1();
        chk("en_hold", q1, 8'h01);
        chk("en_busy", busy1, 1'b1);
        start_dut1(2'b10, 1'b1);
        clk1();
        chk("en_start_hold", q1, 8'h00);
        en1 = 1'b1;
        clk1();
        chk("en_resume", q1, 8'h80);

        // async reset between edges while q=0x3C
        start_dut1(2'b00, 1'b1);
        clk1();
        clk1();
        chk("pre_rst_q", q1, 8'h3C);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_q", q1, 8'h00);
        chk("async_rst_busy", busy1, 1'b0);
        #1 reset = 1'b0;
        clk1();
        chk("post_rst_q", q1, 8'h00);
        chk("post_rst_done", done1, 1'b0);
        chk("post_rst_busy", busy1, 1'b0);

        // start mid-run with mode changed to 11
        start_dut1(2'b00, 1'b0);
        clk1();
        chk("mid_q", q1, 8'h18);
        start_dut1(2'b11, 1'b0);
        clk1();
        chk("mid_restart_q", q1, 8'h01);

        // DIV=3: one step every third enabled clock, done after 15 clocks
        start3 = 1'b1;
        mode3  = 2'b00;
        loop3  = 1'b0;
        clk1();
        start3 = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            clk1();
            if (done3) begin
                n = i;
                break;
            end
            chk($sformatf("div3_q%0d", i), q3, e3[(i / 3 > 4) ? 4 : i / 3]);
        end
        chk("div3_len", n, 15);

        // same sequence with en low for 5 clocks must take exactly 5 more
        start3 = 1'b1;
        clk1();
        start3 = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            en3 = (i >= 5 && i <= 9) ? 1'b0 : 1'b1;
            clk1();
            if (done3) begin
                n = i;
                break;
            end
        end
        en3 = 1'b1;
        chk("div3_en_len", n, 20);
        chk("div3_busy_end", busy3, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
